// File: rtl/cpu_run_ctrl_if.sv
// Command and register-dump channels of the CPU run-control block.
// Latency: none, signal bundle only.
// Backpressure: cmd_valid/cmd_ready on commands, dump_valid/dump_ready on dump beats.
interface cpu_run_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        cmd_err;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  // Debugger / host side: issues commands, sinks dump beats.
  modport master (
    output cmd_valid, cmd_op, cmd_arg, dump_ready,
    input  cmd_ready, cmd_err, dump_valid, dump_idx, dump_data
  );

  // Run controller side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, dump_ready,
    output cmd_ready, cmd_err, dump_valid, dump_idx, dump_data
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run-control/debug sequencer: halt, free-run, N-step, and register dump via the CPU debug port.
// Latency: all outputs registered; state changes take effect the cycle after the accepting edge.
// Backpressure: commands refused (cmd_ready=0) while dumping; a dump beat is held until dump_ready.
module cpu_run_ctrl #(
  parameter int CYC_W        = 32,
  parameter int READ_LAT     = 1,
  parameter int RUN_ON_RESET = 0
) (
  input  logic             clk,
  input  logic             rstn,
  cpu_run_ctrl_if.slave    bus,
  output logic             cpu_en,
  input  logic             cpu_retire,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  output logic [2:0]       state,
  output logic [CYC_W-1:0] cycle_cnt,
  output logic [CYC_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_HALT  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DWAIT = 3'd3,
    S_DOUT  = 3'd4
  } state_t;

  localparam logic [1:0] OP_HALT = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_DUMP = 2'd3;

  localparam logic [2:0]       LP_LAT   = 3'(READ_LAT);
  localparam logic [CYC_W-1:0] LP_ONE   = {{(CYC_W-1){1'b0}}, 1'b1};
  localparam state_t           LP_RST_S = (RUN_ON_RESET != 0) ? S_RUN : S_HALT;
  localparam logic             LP_RST_E = (RUN_ON_RESET != 0);

  state_t            r_state;
  logic [15:0]       r_rem;
  logic [2:0]        r_lat;
  logic [4:0]        r_sel;
  logic              r_cpu_en;
  logic              r_cmd_rdy;
  logic              r_cmd_err;
  logic              r_dvld;
  logic [4:0]        r_didx;
  logic [31:0]       r_ddat;
  logic [CYC_W-1:0]  r_cyc;
  logic [CYC_W-1:0]  r_instret;

  state_t            w_nxt_state;
  logic [15:0]       w_nxt_rem;
  logic [2:0]        w_nxt_lat;
  logic [4:0]        w_nxt_sel;
  logic              w_nxt_err;
  logic              w_nxt_dvld;
  logic [4:0]        w_nxt_didx;
  logic [31:0]       w_nxt_ddat;
  logic              w_acc;
  logic              w_nxt_run;

  // Command acceptance uses the registered ready, so nothing is taken during a dump.
  assign w_acc     = bus.cmd_valid & r_cmd_rdy;
  assign w_nxt_run = (w_nxt_state == S_RUN) || (w_nxt_state == S_STEP);

  // Next-state and next-output decode for the run/step/dump sequencer.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_rem   = r_rem;
    w_nxt_lat   = r_lat;
    w_nxt_sel   = r_sel;
    w_nxt_err   = 1'b0;
    w_nxt_dvld  = r_dvld;
    w_nxt_didx  = r_didx;
    w_nxt_ddat  = r_ddat;
    case (r_state)
      S_HALT: begin
        if (w_acc) begin
          case (bus.cmd_op)
            OP_RUN:  w_nxt_state = S_RUN;
            OP_STEP: begin
              w_nxt_state = S_STEP;
              w_nxt_rem   = (bus.cmd_arg == 16'd0) ? 16'd1 : bus.cmd_arg;
            end
            OP_DUMP: begin
              w_nxt_state = S_DWAIT;
              w_nxt_sel   = 5'd0;
              w_nxt_lat   = LP_LAT;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (w_acc) begin
          if (bus.cmd_op == OP_HALT) begin
            w_nxt_state = S_HALT;
          end else if (bus.cmd_op != OP_RUN) begin
            w_nxt_err = 1'b1;
          end
        end
      end
      S_STEP: begin
        // The final retire ends the step burst; a same-edge HALT lands in the same place.
        if (cpu_retire) begin
          w_nxt_rem = r_rem - 16'd1;
          if (r_rem == 16'd1) begin
            w_nxt_state = S_HALT;
          end
        end
        if (w_acc) begin
          if (bus.cmd_op == OP_HALT) begin
            w_nxt_state = S_HALT;
            w_nxt_rem   = 16'd0;
          end else begin
            w_nxt_err = 1'b1;
          end
        end
      end
      S_DWAIT: begin
        if (r_lat <= 3'd1) begin
          w_nxt_ddat  = reg_data;
          w_nxt_didx  = r_sel;
          w_nxt_dvld  = 1'b1;
          w_nxt_state = S_DOUT;
        end else begin
          w_nxt_lat = r_lat - 3'd1;
        end
      end
      S_DOUT: begin
        if (r_dvld && bus.dump_ready) begin
          w_nxt_dvld = 1'b0;
          if (r_didx == 5'd31) begin
            w_nxt_sel   = 5'd0;
            w_nxt_state = S_HALT;
          end else begin
            w_nxt_sel   = r_didx + 5'd1;
            w_nxt_lat   = LP_LAT;
            w_nxt_state = S_DWAIT;
          end
        end
      end
      default: w_nxt_state = S_HALT;
    endcase
  end

  // State register plus registered copies of every control output.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= LP_RST_S;
      r_cpu_en  <= LP_RST_E;
      r_cmd_rdy <= 1'b1;
      r_cmd_err <= 1'b0;
      r_rem     <= 16'd0;
      r_lat     <= 3'd0;
      r_sel     <= 5'd0;
      r_dvld    <= 1'b0;
      r_didx    <= 5'd0;
      r_ddat    <= 32'd0;
    end else begin
      r_state   <= w_nxt_state;
      r_cpu_en  <= w_nxt_run;
      r_cmd_rdy <= (w_nxt_state != S_DWAIT) && (w_nxt_state != S_DOUT);
      r_cmd_err <= w_nxt_err;
      r_rem     <= w_nxt_rem;
      r_lat     <= w_nxt_lat;
      r_sel     <= w_nxt_sel;
      r_dvld    <= w_nxt_dvld;
      r_didx    <= w_nxt_didx;
      r_ddat    <= w_nxt_ddat;
    end
  end

  // Saturating cycle and retire counters, qualified by the enable the pipeline actually sees.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cyc     <= '0;
      r_instret <= '0;
    end else begin
      if (r_cpu_en && (r_cyc != '1)) begin
        r_cyc <= r_cyc + LP_ONE;
      end
      if (r_cpu_en && cpu_retire && (r_instret != '1)) begin
        r_instret <= r_instret + LP_ONE;
      end
    end
  end

  assign bus.cmd_ready  = r_cmd_rdy;
  assign bus.cmd_err    = r_cmd_err;
  assign bus.dump_valid = r_dvld;
  assign bus.dump_idx   = r_didx;
  assign bus.dump_data  = r_ddat;
  assign cpu_en         = r_cpu_en;
  assign reg_sel        = r_sel;
  assign state          = r_state;
  assign cycle_cnt      = r_cyc;
  assign instret        = r_instret;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: run/halt/step sequencing, counters, register dump and mid-dump reset.
// Latency: commands driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: dump_ready driven randomly or held low to exercise beat stalling.
module tb_cpu_run_ctrl;
  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_en;
  logic        cpu_retire;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] instret;

  cpu_run_ctrl_if bus();

  always #5 clk = ~clk;

  cpu_run_ctrl #(.CYC_W(32), .READ_LAT(RL), .RUN_ON_RESET(0)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .cpu_en     (cpu_en),
    .cpu_retire (cpu_retire),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data),
    .state      (state),
    .cycle_cnt  (cycle_cnt),
    .instret    (instret)
  );

  // CPU debug port model: register i holds 0x1000_0000+i, one register stage (READ_LAT=2).
  logic [31:0] rd_q = 32'd0;
  always @(posedge clk) rd_q <= 32'h1000_0000 + {27'd0, reg_sel};
  assign reg_data = rd_q;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] dat;
  } beat_t;

  beat_t exp_q[$];
  int    n_beats = 0;
  int    n_chk   = 0;
  int    n_fail  = 0;
  int    rdy_mode = 0;
  bit    stop12  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_dump();
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.idx = 5'(i);
      b.dat = 32'h1000_0000 + 32'(i);
      exp_q.push_back(b);
    end
  endtask

  // Scoreboard: every valid beat must match the queue head; a handshake retires it.
  always @(negedge clk) begin
    if (rstn && bus.dump_valid) begin
      if (exp_q.size() == 0) begin
        check("dump_unexpected_beat", 32'(exp_q.size()), 32'd1);
      end else begin
        check("dump_idx", {27'd0, bus.dump_idx}, {27'd0, exp_q[0].idx});
        check("dump_data", bus.dump_data, exp_q[0].dat);
        if (bus.dump_ready) begin
          void'(exp_q.pop_front());
          n_beats++;
        end
      end
    end
  end

  // Dump sink: random, always-ready, or refusing beat 12 when stop12 is set.
  initial begin
    bus.dump_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stop12 && bus.dump_valid && bus.dump_idx == 5'd12) bus.dump_ready = 1'b0;
      else if (rdy_mode == 0) bus.dump_ready = 1'($urandom_range(0, 1));
      else bus.dump_ready = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int nret;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_arg   = 16'd0;
    cpu_retire    = 1'b0;

    // Reset values
    rstn = 1'b0;
    repeat (2) tick();
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_cmd_err", {31'd0, bus.cmd_err}, 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_reg_sel", {27'd0, reg_sel}, 32'd0);
    check("rst_dump_valid", {31'd0, bus.dump_valid}, 32'd0);
    rstn = 1'b1;
    tick();

    // RUN for ten cycles with retire held high
    cpu_retire = 1'b1;
    tick();
    check("halt_ignores_retire", instret, 32'd0);
    send_cmd(2'd1, 16'd0);
    check("run_state", {29'd0, state}, 32'd1);
    check("run_en_first", {31'd0, cpu_en}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("run_en", {31'd0, cpu_en}, 32'd1);
    end
    send_cmd(2'd0, 16'd0);
    cpu_retire = 1'b0;
    check("halt_en", {31'd0, cpu_en}, 32'd0);
    check("halt_state", {29'd0, state}, 32'd0);
    check("run_cycle_cnt", cycle_cnt, 32'd10);
    check("run_instret", instret, 32'd10);

    // STEP 3 with a retire every second cycle
    send_cmd(2'd2, 16'd3);
    check("step3_state", {29'd0, state}, 32'd2);
    check("step3_en_first", {31'd0, cpu_en}, 32'd1);
    nret = 0;
    for (int i = 0; i < 20 && nret < 3; i++) begin
      cpu_retire = i[0];
      tick();
      if (cpu_retire) nret++;
      if (nret == 3) begin
        check("step3_en_drop", {31'd0, cpu_en}, 32'd0);
        check("step3_halt", {29'd0, state}, 32'd0);
      end else begin
        check("step3_en", {31'd0, cpu_en}, 32'd1);
      end
    end
    cpu_retire = 1'b0;
    check("step3_instret", instret, 32'd13);

    // STEP 0 behaves as a single step
    send_cmd(2'd2, 16'd0);
    check("step0_en", {31'd0, cpu_en}, 32'd1);
    cpu_retire = 1'b1;
    repeat (4) tick();
    cpu_retire = 1'b0;
    check("step0_instret", instret, 32'd14);
    check("step0_state", {29'd0, state}, 32'd0);

    // Full register dump with random backpressure
    n_beats  = 0;
    rdy_mode = 0;
    push_dump();
    send_cmd(2'd3, 16'd0);
    check("dump_state", {29'd0, state}, 32'd3);
    check("dump_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    t = 0;
    while (state !== 3'd0 && t < 2000) begin
      tick();
      t++;
    end
    check("dump_finished_in_time", {31'd0, t < 2000}, 32'd1);
    check("dump_beats", 32'(n_beats), 32'd32);
    check("dump_q_left", 32'(exp_q.size()), 32'd0);
    check("dump_end_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("dump_end_reg_sel", {27'd0, reg_sel}, 32'd0);
    check("dump_end_cpu_en", {31'd0, cpu_en}, 32'd0);

    // Illegal DUMP while running
    send_cmd(2'd1, 16'd0);
    send_cmd(2'd3, 16'd0);
    check("run_dump_err", {31'd0, bus.cmd_err}, 32'd1);
    check("run_dump_state", {29'd0, state}, 32'd1);
    tick();
    check("run_dump_err_pulse", {31'd0, bus.cmd_err}, 32'd0);
    send_cmd(2'd0, 16'd0);
    t = int'(instret);

    // STEP 5 interrupted by HALT after two retires
    send_cmd(2'd2, 16'd5);
    cpu_retire = 1'b1;
    repeat (2) tick();
    cpu_retire = 1'b0;
    send_cmd(2'd0, 16'd0);
    check("step5_halt_state", {29'd0, state}, 32'd0);
    check("step5_instret", instret, 32'(t + 2));

    // A following STEP 1 performs exactly one step
    send_cmd(2'd2, 16'd1);
    cpu_retire = 1'b1;
    repeat (3) tick();
    cpu_retire = 1'b0;
    check("step1_instret", instret, 32'(t + 3));
    check("step1_state", {29'd0, state}, 32'd0);

    // HALT command and the final retire on the same edge
    send_cmd(2'd2, 16'd1);
    cpu_retire = 1'b1;
    send_cmd(2'd0, 16'd0);
    cpu_retire = 1'b0;
    check("halt_retire_state", {29'd0, state}, 32'd0);
    check("halt_retire_instret", instret, 32'(t + 4));
    check("halt_retire_err", {31'd0, bus.cmd_err}, 32'd0);

    // Reset while beat 12 is stalled
    rdy_mode = 1;
    stop12   = 1'b1;
    push_dump();
    send_cmd(2'd3, 16'd0);
    t = 0;
    while (!(bus.dump_valid && bus.dump_idx == 5'd12) && t < 500) begin
      tick();
      t++;
    end
    check("beat12_reached", {31'd0, t < 500}, 32'd1);
    rstn = 1'b0;
    tick();
    check("mid_rst_dump_valid", {31'd0, bus.dump_valid}, 32'd0);
    check("mid_rst_reg_sel", {27'd0, reg_sel}, 32'd0);
    check("mid_rst_state", {29'd0, state}, 32'd0);
    check("mid_rst_cycle_cnt", cycle_cnt, 32'd0);
    check("mid_rst_instret", instret, 32'd0);
    check("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rstn   = 1'b1;
    stop12 = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    check("post_rst_idle", {31'd0, bus.dump_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run-control and debug sequencer for the 5-stage pipeline CPU (comp). It gates pipeline advance through a global enable and supports free-run, halt and single/N-instruction stepping. It counts enabled cycles and retired instructions. While halted, it scans all 32 architectural registers through the CPU's reg_sel/reg_data debug port and streams them out over a valid/ready interface.

Parameters:
CYC_W, 32, width of cycle_cnt and instret counters (saturating)
READ_LAT, 1, cycles from reg_sel update to reg_data valid; legal 1..4
RUN_ON_RESET, 0, 1 = leave reset in RUN with cpu_en=1

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at posedge
cmd_op  in  2  0=HALT 1=RUN 2=STEP 3=DUMP
cmd_arg  in  16  STEP count; ignored for other ops
cmd_err  out  1  one-cycle pulse: accepted command illegal in current state
cpu_en  out  1  pipeline advance enable (0 = all stages frozen, in-flight state held)
cpu_retire  in  1  pulse per instruction retiring in WB
reg_sel  out  5  register index to CPU debug port
reg_data  in  32  register value from CPU debug port
dump_valid  out  1  dump beat valid
dump_ready  in  1  dump sink ready
dump_idx  out  5  register index of current beat
dump_data  out  32  register value of current beat
state  out  3  0=HALT 1=RUN 2=STEP 3=DWAIT 4=DOUT
cycle_cnt  out  CYC_W  cycles with cpu_en=1
instret  out  CYC_W  retires counted while cpu_en=1

Behaviour:
- Reset values: state=HALT (RUN if RUN_ON_RESET), cpu_en=0 (1 if RUN_ON_RESET), cmd_ready=1, cmd_err=0, reg_sel=0, dump_valid=0, dump_idx=0, dump_data=0, cycle_cnt=0, instret=0, step remaining=0.
- All outputs are registered. cpu_en equals 1 exactly when state is RUN or STEP.
- cmd_ready=1 in HALT/RUN/STEP and 0 in DWAIT/DOUT. A command is accepted on the edge where cmd_valid&cmd_ready.
- HALT state:
  - RUN -> RUN.
  - STEP -> STEP, remaining=cmd_arg (0 treated as 1).
  - DUMP -> DWAIT, reg_sel=0, latency counter=READ_LAT.
  - HALT -> no-op, no error.
- RUN state:
  - HALT -> HALT; cpu_en is 0 from the next cycle.
  - RUN -> no-op.
  - STEP or DUMP -> cmd_err pulse, state unchanged.
- STEP state:
  - On each cpu_retire, remaining decrements. On the edge where cpu_retire=1 and remaining==1, go to HALT; cpu_en is 0 the cycle after the final retire.
  - HALT command -> HALT, remaining cleared.
  - RUN, STEP or DUMP -> cmd_err pulse, state unchanged.
  - A HALT command and the final retire on the same edge -> HALT, retire is counted.
- DWAIT: count down READ_LAT cycles, then capture reg_data into dump_data, set dump_idx=reg_sel and dump_valid=1, go to DOUT.
- DOUT:
  - dump_valid, dump_idx and dump_data stay stable until dump_ready.
  - On handshake with idx<31: dump_valid=0, reg_sel=idx+1, go to DWAIT.
  - On handshake with idx==31: dump_valid=0, reg_sel=0, go to HALT.
  - Beats are strictly ordered x0..x31. x0 reports whatever the CPU returns.
- Counters:
  - cycle_cnt increments every cycle cpu_en=1.
  - instret increments on cpu_retire while cpu_en=1; retires with cpu_en=0 are ignored.
  - Both saturate at all-ones and are cleared only by reset.
- Reset mid-operation (any state, including DOUT with valid high) returns all outputs to reset values on that edge. No partial dump resumes.
- cmd_err is never asserted in DWAIT/DOUT, because commands are not accepted there.

Test Plan:
1. Reset, RUN_ON_RESET=0 -> state=0, cpu_en=0, cmd_ready=1, cycle_cnt=0, instret=0, reg_sel=0.
2. RUN accepted at edge k, HALT accepted at edge k+10, cpu_retire held 1 -> cpu_en=1 for cycles k+1..k+10, then cycle_cnt=10, instret=10.
3. STEP arg=3 with cpu_retire every 2nd cycle -> cpu_en drops the cycle after the 3rd retire, instret=3, state=HALT. STEP arg=0 -> exactly 1 retire.
4. DUMP from HALT, CPU model reg i = 0x1000_0000+i, READ_LAT=2, dump_ready random -> 32 beats with idx 0..31, data 0x1000_0000..0x1000_001F, beat held stable while ready=0, then state=HALT, cmd_ready=1, reg_sel=0.
5. In RUN send DUMP -> one-cycle cmd_err, state stays RUN. STEP arg=5, HALT after 2 retires -> HALT, instret=2, a following STEP arg=1 performs 1 step.
6. Assert rstn=0 for one cycle in DOUT at idx=12 with dump_ready=0 -> next cycle dump_valid=0, reg_sel=0, state=HALT, counters 0.
